// File: rtl/vga_scandoubler.sv
// vga_scandoubler: doubles a 15 kHz video line into two 31 kHz VGA lines.
//
// Each incoming line (7 MHz pixels) is captured into one half of a ping-pong
// line buffer while the other half, holding the previous complete line, is
// played out twice at 14 MHz.
//
// Ports:
//   clk          28 MHz system clock, sole clock
//   rst          synchronous reset, active-high
//   ri/gi/bi     3-bit colour from the machine core (15 kHz timing)
//   hsync_n_in   15 kHz horizontal sync, active-low
//   vsync_n_in   15 kHz vertical sync, active-low
//   ro/go/bo     3-bit doubled-scan colour
//   hsync_n_out  VGA horizontal sync, active-low
//   vsync_n_out  VGA vertical sync, active-low
module vga_scandoubler #(
    parameter int unsigned HTOTAL    = 448,
    parameter int unsigned HSYNC_LEN = 54
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] ri,
    input  logic [2:0] gi,
    input  logic [2:0] bi,
    input  logic       hsync_n_in,
    input  logic       vsync_n_in,
    output logic [2:0] ro,
    output logic [2:0] go,
    output logic [2:0] bo,
    output logic       hsync_n_out,
    output logic       vsync_n_out
);

    localparam logic [8:0] HTOT  = 9'(HTOTAL);
    localparam logic [8:0] HLAST = 9'(HTOTAL - 1);
    localparam logic [8:0] HSLEN = 9'(HSYNC_LEN);

    logic [1:0] r_divs;
    logic       r_hs_prev;
    logic       r_vs_in;
    logic [8:0] r_wr_addr;
    logic [8:0] r_rd_addr;
    logic       r_wr_bank;
    logic       r_line_valid;

    // Both banks live in one array; the top address bit selects the bank.
    logic [8:0] r_mem [0:1023];
    logic [8:0] r_rd_data;

    logic       r_hs_p1;
    logic       r_lv_p1;
    logic       r_vs_p1;

    logic       w_in_en;
    logic       w_out_en;
    logic       w_line_start;
    logic       w_we;

    assign w_in_en      = (r_divs == 2'b11);
    assign w_out_en     = r_divs[0];
    assign w_line_start = w_in_en && r_hs_prev && !hsync_n_in;
    // Writes stop once the line buffer is full; reset blocks the write too.
    assign w_we         = !rst && w_in_en && !w_line_start && (r_wr_addr < HTOT);

    // Timing, address generation and bank control.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_divs       <= 2'd0;
            r_hs_prev    <= 1'b1;
            r_vs_in      <= 1'b1;
            r_wr_addr    <= 9'd0;
            r_rd_addr    <= 9'd0;
            r_wr_bank    <= 1'b0;
            r_line_valid <= 1'b0;
        end else begin
            r_divs <= r_divs + 2'd1;
            if (w_in_en) begin
                r_hs_prev <= hsync_n_in;
                r_vs_in   <= vsync_n_in;
            end
            if (w_line_start) begin
                // Line start wins over the read-side increment/wrap.
                r_wr_addr    <= 9'd0;
                r_wr_bank    <= ~r_wr_bank;
                r_rd_addr    <= 9'd0;
                r_line_valid <= 1'b1;
            end else begin
                if (w_we) begin
                    r_wr_addr <= r_wr_addr + 9'd1;
                end
                if (w_out_en) begin
                    r_rd_addr <= (r_rd_addr == HLAST) ? 9'd0 : r_rd_addr + 9'd1;
                end
            end
        end
    end

    // Line buffer: not reset, synchronous read of the bank not being written.
    always_ff @(posedge clk) begin
        if (w_we) begin
            r_mem[{r_wr_bank, r_wr_addr}] <= {ri, gi, bi};
        end
        r_rd_data <= r_mem[{~r_wr_bank, r_rd_addr}];
    end

    // Sync and valid flags travel alongside the RAM read so that everything
    // leaves the output register on the same clock.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hs_p1     <= 1'b1;
            r_lv_p1     <= 1'b0;
            r_vs_p1     <= 1'b1;
            hsync_n_out <= 1'b1;
            vsync_n_out <= 1'b1;
            ro          <= 3'd0;
            go          <= 3'd0;
            bo          <= 3'd0;
        end else begin
            r_hs_p1     <= (r_rd_addr >= HSLEN);
            r_lv_p1     <= r_line_valid;
            r_vs_p1     <= r_vs_in;
            hsync_n_out <= r_hs_p1;
            vsync_n_out <= r_vs_p1;
            if (r_hs_p1 && r_lv_p1) begin
                {ro, go, bo} <= r_rd_data;
            end else begin
                {ro, go, bo} <= 9'd0;
            end
        end
    end

endmodule

// File: doc/vga_scandoubler.md
VGA_SCANDOUBLER -- requirements
Module: vga_scandoubler

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-high.
REQ-002 Parameter HTOTAL, default 448: input clocks per line at 7 MHz, legal range 256..511.
REQ-003 Parameter HSYNC_LEN, default 54: output hsync width in 14 MHz out-pixels, legal range 1..HTOTAL-1.
REQ-004 Port clk, input, 1 bit: 28 MHz system clock (sysclk); sole clock.
REQ-005 Port rst, input, 1 bit: synchronous reset, active-high.
REQ-006 Port ri, gi, bi, inputs, 3 bits each: 15 kHz pixel colour from the machine core.
REQ-007 Port hsync_n_in, vsync_n_in, inputs, 1 bit each: 15 kHz syncs, active-low.
REQ-008 Port ro, go, bo, outputs, 3 bits each: 31 kHz doubled-scan colour.
REQ-009 Port hsync_n_out, vsync_n_out, outputs, 1 bit each: VGA syncs, active-low.

Function
REQ-010 The block SHALL keep an internal 2-bit counter divs incrementing every clk.
- in_en when divs==2'b11 (7 MHz).
- out_en when divs[0]==1 (14 MHz).
REQ-011 The block SHALL hold two 512x9 line banks (ping-pong), selected by wr_bank; RAM contents are not reset.
REQ-012 On each in_en, hs_prev SHALL take hsync_n_in; a line start is hs_prev==1 and hsync_n_in==0 on that in_en.
REQ-013 On a line start, wr_addr SHALL be set to 0, wr_bank SHALL toggle, rd_addr SHALL be set to 0 and line_valid SHALL be set to 1.
- Line start overrides any same-cycle rd_addr wrap or increment.
REQ-014 On in_en without a line start, while wr_addr<HTOTAL, {ri,gi,bi} SHALL be written to bank wr_bank at wr_addr and wr_addr SHALL increment.
REQ-015 Once wr_addr reaches HTOTAL, wr_addr SHALL saturate at HTOTAL and further writes SHALL be suppressed until the next line start.
REQ-016 On out_en, rd_addr SHALL increment, wrapping HTOTAL-1 -> 0, which yields two output lines per input line.
REQ-017 Reads SHALL come from bank ~wr_bank (the previously completed line) with a synchronous RAM read of 1 clk.
REQ-018 The output stage SHALL register the read data once more, for a total latency of 2 clk from rd_addr to ro/go/bo.
REQ-019 hsync_n_out SHALL be 0 while rd_addr<HSYNC_LEN, else 1, and SHALL be delayed 2 clk to align with colour.
REQ-020 ro/go/bo SHALL be forced to 0 while the aligned hsync_n_out==0 or line_valid==0.
REQ-021 vsync_n_out SHALL be vsync_n_in sampled on in_en, then delayed through the same 2-clk pipeline.
REQ-022 An input line shorter than HTOTAL SHALL resync rd_addr early; the stale bank tail SHALL be replayed without error.
REQ-023 If hsync_n_in is held low with no edge, line starts SHALL stop.
- wr_addr saturates at HTOTAL.
- rd_addr free-runs with the wrap rule.

Reset
REQ-024 While rst==1 at a clk edge, the following SHALL hold: divs=0, wr_addr=0, rd_addr=0, wr_bank=0, hs_prev=1, line_valid=0, ro/go/bo=0, hsync_n_out=1, vsync_n_out=1.
REQ-025 After rst deasserts, ro/go/bo SHALL stay 0 until the first line start has occurred and its pipeline delay has elapsed.
REQ-026 Reset asserted mid-line SHALL abandon the line; no partial write SHALL occur on the reset cycle.

Verification
REQ-027 Reset, then drive 3 lines of HTOTAL=448 with a pixel value equal to column mod 8 -> from the 2nd line onward, ro cycles 0..7; each column is repeated for 2 clk; 2 output lines per input line.
REQ-028 Line start on in_en -> hsync_n_out low exactly 2*HSYNC_LEN=108 clk, starting 2 clk after rd_addr=0; second pulse 896 clk after the first.
REQ-029 Input line of 300 clocks (short) -> rd_addr returns to 0 at the line start, hsync_n_out re-asserts early, no X on outputs.
REQ-030 hsync_n_in held low for 2000 in_en -> wr_addr stays 448; hsync_n_out keeps a 896-clk period.
REQ-031 rst pulsed for 1 clk mid-line after valid video -> next clk ro/go/bo=0, hsync_n_out=1; video is blanked until the next line start.
REQ-032 vsync_n_in pulse 3 lines long -> vsync_n_out low for 3*1792 clk, same 2-clk alignment as hsync_n_out.
